// File: rtl/lamp_sequence_monitor.sv
// Passive checker for the RGY lamp bus: follows RED->GREEN->YELLOW->RED and
// flags bad encodings, out-of-order colours and wrong dwell times.
//
// state  | meaning
// SYNC   | waiting for a legal successor transition to lock onto
// RED    | locked, lamp currently red
// GREEN  | locked, lamp currently green
// YELLOW | locked, lamp currently yellow
module lamp_sequence_monitor #(
  parameter int RED_CYCLES    = 1,
  parameter int GREEN_CYCLES  = 1,
  parameter int YELLOW_CYCLES = 1,
  parameter int CNT_W         = 8,
  parameter int ERR_CNT_W     = 8,
  parameter int CYC_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:2]           light,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [CYC_CNT_W-1:0] cycle_count
);

  localparam logic [0:2] L_RED    = 3'b100;
  localparam logic [0:2] L_GREEN  = 3'b010;
  localparam logic [0:2] L_YELLOW = 3'b001;

  localparam logic [1:0] E_ILLEGAL = 2'b00;
  localparam logic [1:0] E_ORDER   = 2'b01;
  localparam logic [1:0] E_SHORT   = 2'b10;
  localparam logic [1:0] E_LONG    = 2'b11;

  typedef enum logic [1:0] {SYNC, RED, GREEN, YELLOW} state_t;

  state_t           state;
  logic [0:2]       prev;
  logic [CNT_W-1:0] dwell;

  logic [0:2]       cur_l;
  logic [0:2]       next_l;
  logic [CNT_W-1:0] req;
  logic [CNT_W-1:0] dwell_inc;
  logic             lock_ok;
  logic             err_det;
  logic [1:0]       err_cls;

  function automatic logic is_onehot(input logic [0:2] l);
    return (l == L_RED) || (l == L_GREEN) || (l == L_YELLOW);
  endfunction

  // Non-colour inputs map to 000 so they can never match a legal sample.
  function automatic logic [0:2] succ(input logic [0:2] l);
    case (l)
      L_RED:    return L_GREEN;
      L_GREEN:  return L_YELLOW;
      L_YELLOW: return L_RED;
      default:  return 3'b000;
    endcase
  endfunction

  function automatic state_t state_of(input logic [0:2] l);
    case (l)
      L_RED:    return RED;
      L_GREEN:  return GREEN;
      L_YELLOW: return YELLOW;
      default:  return SYNC;
    endcase
  endfunction

  always_comb begin
    cur_l = 3'b000;
    req   = '0;
    case (state)
      RED:    begin cur_l = L_RED;    req = CNT_W'(RED_CYCLES);    end
      GREEN:  begin cur_l = L_GREEN;  req = CNT_W'(GREEN_CYCLES);  end
      YELLOW: begin cur_l = L_YELLOW; req = CNT_W'(YELLOW_CYCLES); end
      default: ;
    endcase
    next_l    = succ(cur_l);
    dwell_inc = (dwell == '1) ? dwell : dwell + CNT_W'(1);
    lock_ok   = is_onehot(prev) && (light == succ(prev));

    // Classes are mutually exclusive per sample, so the if-chain order is the priority.
    err_det = 1'b0;
    err_cls = E_ILLEGAL;
    if (state != SYNC) begin
      if (!is_onehot(light)) begin
        err_det = 1'b1;
        err_cls = E_ILLEGAL;
      end else if (light == cur_l) begin
        if (dwell_inc > req) begin
          err_det = 1'b1;
          err_cls = E_LONG;
        end
      end else if (light == next_l) begin
        if (dwell != req) begin
          err_det = 1'b1;
          err_cls = E_SHORT;
        end
      end else begin
        err_det = 1'b1;
        err_cls = E_ORDER;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SYNC;
      prev        <= 3'b000;
      dwell       <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_code    <= E_ILLEGAL;
      err_count   <= '0;
      cycle_count <= '0;
    end else begin
      prev      <= light;
      err_pulse <= 1'b0;
      if (state == SYNC) begin
        if (lock_ok) begin
          state  <= state_of(light);
          dwell  <= CNT_W'(1);
          locked <= 1'b1;
        end
      end else if (err_det) begin
        state     <= SYNC;
        dwell     <= '0;
        locked    <= 1'b0;
        err_pulse <= 1'b1;
        err_code  <= err_cls;
        if (err_count != '1)
          err_count <= err_count + ERR_CNT_W'(1);
      end else if (light == cur_l) begin
        dwell <= dwell_inc;
      end else begin
        state <= state_of(light);
        dwell <= CNT_W'(1);
        if (state == YELLOW)
          cycle_count <= cycle_count + CYC_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Bench for lamp_sequence_monitor: a behavioural model feeds a scoreboard queue
// every cycle, and each scenario task adds its own targeted checks.
module tb_lamp_sequence_monitor;

  localparam int RED_C = 3;
  localparam int GRN_C = 2;
  localparam int YEL_C = 1;

  localparam logic [0:2] R   = 3'b100;
  localparam logic [0:2] G   = 3'b010;
  localparam logic [0:2] Y   = 3'b001;
  localparam logic [0:2] OFF = 3'b000;
  localparam logic [0:2] ALL = 3'b111;
  localparam logic [0:2] RG  = 3'b110;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:2]  light;
  logic        locked;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [1:0]  err_count;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;

  logic [21:0] sb[$];

  // model state: colour index 0=none/sync, 1=R, 2=G, 3=Y
  int          m_st;
  int          m_dw;
  logic [0:2]  m_prev;
  logic        m_lk;
  logic        m_pl;
  logic [1:0]  m_cd;
  logic [1:0]  m_ec;
  logic [15:0] m_cc;

  lamp_sequence_monitor #(
    .RED_CYCLES(RED_C), .GREEN_CYCLES(GRN_C), .YELLOW_CYCLES(YEL_C),
    .CNT_W(8), .ERR_CNT_W(2), .CYC_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .light(light), .locked(locked),
    .err_pulse(err_pulse), .err_code(err_code),
    .err_count(err_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  function automatic int col_of(input logic [0:2] l);
    if (l === R) return 1;
    if (l === G) return 2;
    if (l === Y) return 3;
    return 0;
  endfunction

  function automatic int req_of(input int c);
    if (c == 1) return RED_C;
    if (c == 2) return GRN_C;
    return YEL_C;
  endfunction

  task automatic model(input logic [0:2] l, input logic r);
    int c, p;
    logic bad;
    logic [1:0] code;
    if (r) begin
      m_st = 0; m_dw = 0; m_prev = OFF; m_lk = 0; m_pl = 0;
      m_cd = 0; m_ec = 0; m_cc = 0;
      return;
    end
    c = col_of(l);
    p = col_of(m_prev);
    m_pl = 0;
    bad = 0;
    code = 0;
    if (m_st == 0) begin
      if (p != 0 && c == (p % 3) + 1) begin
        m_st = c; m_dw = 1; m_lk = 1;
      end
    end else begin
      if (c == 0) begin
        bad = 1; code = 2'b00;
      end else if (c == m_st) begin
        if (m_dw < 255) m_dw = m_dw + 1;
        if (m_dw > req_of(m_st)) begin bad = 1; code = 2'b11; end
      end else if (c == (m_st % 3) + 1) begin
        if (m_dw < req_of(m_st)) begin
          bad = 1; code = 2'b10;
        end else begin
          if (m_st == 3) m_cc = m_cc + 16'd1;
          m_st = c; m_dw = 1;
        end
      end else begin
        bad = 1; code = 2'b01;
      end
      if (bad) begin
        m_pl = 1; m_cd = code; m_lk = 0; m_st = 0; m_dw = 0;
        if (m_ec != 2'b11) m_ec = m_ec + 2'd1;
      end
    end
    m_prev = l;
  endtask

  // Drive one sample, record what the monitor must show after the edge.
  task automatic step(input logic [0:2] l, input logic r);
    light = l;
    rst   = r;
    model(l, r);
    sb.push_back({m_lk, m_pl, m_cd, m_ec, m_cc});
    @(posedge clk);
    #3;
  endtask

  always @(posedge clk) begin
    logic [21:0] exp_v;
    logic [21:0] got_v;
    #2;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      got_v = {locked, err_pulse, err_code, err_count, cycle_count};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL scoreboard t=%0t got lk/pl/cd/ec/cc=%h want %h", $time, got_v, exp_v);
      end
    end
  end

  task automatic relock_red();
    step(OFF, 1'b1);
    step(Y, 1'b0);
    step(R, 1'b0);
  endtask

  task automatic test_reset();
    step(OFF, 1'b1);
    step(R, 1'b1);
    checks++;
    if ({locked, err_pulse, err_code, err_count, cycle_count} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {locked, err_pulse, err_code, err_count, cycle_count});
    end
  endtask

  task automatic test_normal();
    logic saw_pulse;
    saw_pulse = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step(R, 1'b0); saw_pulse |= err_pulse;
      step(R, 1'b0); saw_pulse |= err_pulse;
      step(R, 1'b0); saw_pulse |= err_pulse;
      checks++;
      if (n == 0 && locked !== 1'b0) begin
        errors++;
        $display("FAIL prelock_locked got %b want 0", locked);
      end
      step(G, 1'b0); saw_pulse |= err_pulse;
      if (n == 0) begin
        checks++;
        if (locked !== 1'b1) begin
          errors++;
          $display("FAIL lock_on_rg got %b want 1", locked);
        end
      end
      step(G, 1'b0); saw_pulse |= err_pulse;
      step(Y, 1'b0); saw_pulse |= err_pulse;
    end
    checks++;
    if (saw_pulse !== 1'b0) begin
      errors++;
      $display("FAIL normal_no_err got %b want 0", saw_pulse);
    end
    checks++;
    if (cycle_count !== 16'd4) begin
      errors++;
      $display("FAIL normal_cycles got %0d want 4", cycle_count);
    end
    step(R, 1'b0);
    checks++;
    if (cycle_count !== 16'd5) begin
      errors++;
      $display("FAIL normal_cycles_yr got %0d want 5", cycle_count);
    end
  endtask

  task automatic test_long();
    relock_red();
    step(R, 1'b0);
    step(R, 1'b0);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL long_early got %b want 0", err_pulse);
    end
    step(R, 1'b0);
    checks++;
    if ({err_pulse, err_code, err_count, locked} !== {1'b1, 2'b11, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL long_err got pl=%b cd=%b ec=%0d lk=%b want 1 11 1 0", err_pulse, err_code, err_count, locked);
    end
    step(OFF, 1'b0);
    checks++;
    if (err_pulse !== 1'b0 || err_code !== 2'b11) begin
      errors++;
      $display("FAIL long_hold got pl=%b cd=%b want 0 11", err_pulse, err_code);
    end
  endtask

  task automatic test_short_order();
    relock_red();
    step(R, 1'b0);
    step(R, 1'b0);
    step(G, 1'b0);
    step(Y, 1'b0);
    checks++;
    if (err_pulse !== 1'b1 || err_code !== 2'b10) begin
      errors++;
      $display("FAIL short_err got pl=%b cd=%b want 1 10", err_pulse, err_code);
    end
    relock_red();
    step(Y, 1'b0);
    checks++;
    if (err_pulse !== 1'b1 || err_code !== 2'b01 || locked !== 1'b0) begin
      errors++;
      $display("FAIL order_err got pl=%b cd=%b lk=%b want 1 01 0", err_pulse, err_code, locked);
    end
  endtask

  task automatic test_illegal();
    relock_red();
    step(RG, 1'b0);
    checks++;
    if (err_pulse !== 1'b1 || err_code !== 2'b00 || err_count !== 2'd1) begin
      errors++;
      $display("FAIL illegal_err got pl=%b cd=%b ec=%0d want 1 00 1", err_pulse, err_code, err_count);
    end
    step(OFF, 1'b0);
    step(ALL, 1'b0);
    checks++;
    if (err_pulse !== 1'b0 || err_count !== 2'd1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL unlocked_quiet got pl=%b ec=%0d lk=%b want 0 1 0", err_pulse, err_count, locked);
    end
  endtask

  task automatic test_saturation();
    step(OFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(Y, 1'b0);
      step(R, 1'b0);
      case (i)
        0: step(ALL, 1'b0);
        1: step(Y, 1'b0);
        2: step(G, 1'b0);
        3: step(OFF, 1'b0);
        default: begin
          step(R, 1'b0);
          step(R, 1'b0);
          step(R, 1'b0);
        end
      endcase
      if (i == 3) begin
        checks++;
        if (err_count !== 2'd3 || err_pulse !== 1'b1) begin
          errors++;
          $display("FAIL sat_fourth got ec=%0d pl=%b want 3 1", err_count, err_pulse);
        end
      end
    end
    checks++;
    if (err_count !== 2'd3 || err_code !== 2'b11) begin
      errors++;
      $display("FAIL sat_final got ec=%0d cd=%b want 3 11", err_count, err_code);
    end
  endtask

  task automatic test_midgreen_reset();
    relock_red();
    step(R, 1'b0);
    step(R, 1'b0);
    step(G, 1'b0);
    step(G, 1'b1);
    checks++;
    if ({locked, err_pulse, err_code, err_count, cycle_count} !== 22'd0) begin
      errors++;
      $display("FAIL midrst_outputs got %h want 0", {locked, err_pulse, err_code, err_count, cycle_count});
    end
    step(G, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL midrst_nolock got %b want 0", locked);
    end
    step(Y, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL midrst_relock got lk=%b pl=%b want 1 0", locked, err_pulse);
    end
    step(R, 1'b0);
    checks++;
    if (err_pulse !== 1'b0 || cycle_count !== 16'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL midrst_first_dwell got pl=%b cc=%0d lk=%b want 0 1 1", err_pulse, cycle_count, locked);
    end
  endtask

  initial begin
    rst   = 1'b1;
    light = OFF;
    test_reset();
    test_normal();
    test_long();
    test_short_order();
    test_illegal();
    test_saturation();
    test_midgreen_reset();
    repeat (2) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
